// File: rtl/eg4_rstgen_if.sv
// Reset/timebase bundle between eg4_rstgen and the system top.
// Latency: n/a (wiring only); master drives resets and strobes, slave drives the button.
// Backpressure: none, every signal is a level or a free-running strobe.
interface eg4_rstgen_if;
  logic ext_reset;  // raw board button, active-low
  logic pwr_rst;    // power-on reset, active-high
  logic sys_rst;    // system reset, active-high
  logic sys_us;     // 1-cycle strobe per microsecond
  logic sys_ms;     // 1-cycle strobe per millisecond
  logic sys_ready;  // high only while the system runs

  modport master (
    input  ext_reset,
    output pwr_rst, sys_rst, sys_us, sys_ms, sys_ready
  );

  modport slave (
    output ext_reset,
    input  pwr_rst, sys_rst, sys_us, sys_ms, sys_ready
  );
endinterface

// File: rtl/eg4_rstgen.sv
// Reset sequencer + us/ms timebase: PWR -> SYS -> RUN, debounced button forces BTN.
// Latency: strobes/resets registered; state outputs change 1 cycle after the deciding sys_ms.
// Backpressure: none. Macro CONFIG_RST_BTN_PWR_EN: button release restarts from PWR.
module eg4_rstgen #(
  parameter int CLK_FREQ = 50000000,
  parameter int PWR_MS   = 10,
  parameter int RST_MS   = 2,
  parameter int DEB_MS   = 5
) (
  input  logic          clk,
  input  logic          rst,
  eg4_rstgen_if.master  rg
);

  localparam int          US_DIV  = CLK_FREQ / 1000000;
  localparam logic [7:0]  US_LAST = 8'(US_DIV - 1);
  localparam logic [9:0]  MS_LAST = 10'd999;
  localparam logic [7:0]  PWR_T   = 8'(PWR_MS);
  localparam logic [7:0]  RST_T   = 8'(RST_MS);
  localparam logic [3:0]  DEB_T   = 4'(DEB_MS);

  typedef enum logic [1:0] {
    ST_PWR = 2'd0,
    ST_SYS = 2'd1,
    ST_RUN = 2'd2,
    ST_BTN = 2'd3
  } state_t;

  // timebase
  logic [7:0] us_cnt_q, us_cnt_d;
  logic [9:0] ms_cnt_q, ms_cnt_d;
  logic       us_tick, ms_tick;
  logic       sys_us_q, sys_ms_q;

  // button path
  logic       btn_s1_q, btn_s2_q;
  logic       btn_q, btn_d;
  logic [3:0] deb_cnt_q, deb_cnt_d;

  // sequencer
  state_t     state_q, state_d;
  logic [7:0] tmr_q, tmr_d;
  logic       pwr_rst_q, pwr_rst_d;
  logic       sys_rst_q, sys_rst_d;
  logic       ready_q, ready_d;

  // Free-running divider; the strobes are registered copies of the wrap conditions.
  always_comb begin
    us_tick  = (us_cnt_q == US_LAST);
    ms_tick  = us_tick && (ms_cnt_q == MS_LAST);
    us_cnt_d = us_tick ? 8'd0 : us_cnt_q + 8'd1;
    ms_cnt_d = ms_cnt_q;
    if (us_tick) begin
      ms_cnt_d = ms_tick ? 10'd0 : ms_cnt_q + 10'd1;
    end
  end

  // Divider state and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      us_cnt_q <= 8'd0;
      ms_cnt_q <= 10'd0;
      sys_us_q <= 1'b0;
      sys_ms_q <= 1'b0;
    end else begin
      us_cnt_q <= us_cnt_d;
      ms_cnt_q <= ms_cnt_d;
      sys_us_q <= us_tick;
      sys_ms_q <= ms_tick;
    end
  end

  // Two-flop synchroniser for the asynchronous button, idle level = released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q <= 1'b1;
      btn_s2_q <= 1'b1;
    end else begin
      btn_s1_q <= rg.ext_reset;
      btn_s2_q <= btn_s1_q;
    end
  end

  // Debounce: the synced level must differ from btn on DEB_MS consecutive ms samples.
  always_comb begin
    btn_d     = btn_q;
    deb_cnt_d = deb_cnt_q;
    if (sys_ms_q) begin
      if (btn_s2_q != btn_q) begin
        if (deb_cnt_q + 4'd1 == DEB_T) begin
          btn_d     = btn_s2_q;
          deb_cnt_d = 4'd0;
        end else begin
          deb_cnt_d = deb_cnt_q + 4'd1;
        end
      end else begin
        deb_cnt_d = 4'd0;
      end
    end
  end

  // Debounced button level and its sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q     <= 1'b1;
      deb_cnt_q <= 4'd0;
    end else begin
      btn_q     <= btn_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Next state, state timer and next-cycle output levels decoded from the next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PWR: if (sys_ms_q && (tmr_q + 8'd1 == PWR_T)) state_d = ST_SYS;
      ST_SYS: if (sys_ms_q && (tmr_q + 8'd1 == RST_T)) state_d = ST_RUN;
      ST_RUN: if (!btn_q) state_d = ST_BTN;
      ST_BTN: begin
        if (btn_q) begin
`ifdef CONFIG_RST_BTN_PWR_EN
          state_d = ST_PWR;
`else
          state_d = ST_SYS;
`endif
        end
      end
      default: state_d = ST_PWR;
    endcase

    // Timer restarts on any state change so the new state counts from 0.
    tmr_d = (state_d != state_q) ? 8'd0 : tmr_q + {7'd0, sys_ms_q};

`ifdef CONFIG_RST_BTN_PWR_EN
    pwr_rst_d = (state_d == ST_PWR) || (state_d == ST_BTN);
`else
    pwr_rst_d = (state_d == ST_PWR);
`endif
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
  end

  // State register and registered reset/ready outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_PWR;
      tmr_q     <= 8'd0;
      pwr_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      pwr_rst_q <= pwr_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

  assign rg.pwr_rst   = pwr_rst_q;
  assign rg.sys_rst   = sys_rst_q;
  assign rg.sys_us    = sys_us_q;
  assign rg.sys_ms    = sys_ms_q;
  assign rg.sys_ready = ready_q;

endmodule

// File: tb/tb_eg4_rstgen.sv
// Directed bench for eg4_rstgen at 4 MHz (1 ms = 4000 cycles), PWR_MS=3, RST_MS=2, DEB_MS=2.
// Cycle n = value sampled 1 unit after the n-th rising edge following rst release.
// Scenarios: power-up, reset in SYS, early button + release, glitch, press in RUN, reset in BTN.
module tb_eg4_rstgen;

  localparam int CLK_FREQ = 4000000;
  localparam int PWR_MS   = 3;
  localparam int RST_MS   = 2;
  localparam int DEB_MS   = 2;

`ifdef CONFIG_RST_BTN_PWR_EN
  localparam logic BTN_PWR = 1'b1;
  localparam int   REL_RUN = 48001;  // BTN -> PWR(3 ms) -> SYS(2 ms) -> RUN
`else
  localparam logic BTN_PWR = 1'b0;
  localparam int   REL_RUN = 36001;  // BTN -> SYS(2 ms) -> RUN
`endif
  localparam int G0 = REL_RUN + 999;    // glitch start, 1000 cycles after a ms strobe
  localparam int P  = REL_RUN + 11998;  // press one cycle before a ms strobe

  logic clk = 1'b0;
  logic rst = 1'b1;
  eg4_rstgen_if rg();

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;
  bit seen_pwr, seen_sys_lo, seen_sys_hi, seen_nrdy;

  eg4_rstgen #(
    .CLK_FREQ (CLK_FREQ),
    .PWR_MS   (PWR_MS),
    .RST_MS   (RST_MS),
    .DEB_MS   (DEB_MS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rg  (rg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rg.pwr_rst)    seen_pwr    = 1'b1;
      if (!rg.sys_rst)   seen_sys_lo = 1'b1;
      if (rg.sys_rst)    seen_sys_hi = 1'b1;
      if (!rg.sys_ready) seen_nrdy   = 1'b1;
    end
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_pwr"},   rg.pwr_rst,   1);
    chk({tag, "_sys"},   rg.sys_rst,   1);
    chk({tag, "_us"},    rg.sys_us,    0);
    chk({tag, "_ms"},    rg.sys_ms,    0);
    chk({tag, "_ready"}, rg.sys_ready, 0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    rg.ext_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_vals("por");

    // Power-up: strobes, then pwr_rst falls at 12001; reset hits while in SYS.
    release_rst();
    for (int i = 1; i <= 12; i++) begin
      step_to(i);
      chk("us_strobe", rg.sys_us, (i % 4 == 0) ? 1 : 0);
    end
    step_to(3999);  chk("ms_before", rg.sys_ms, 0);
    step_to(4000);  chk("ms_first", rg.sys_ms, 1); chk("us_with_ms", rg.sys_us, 1);
    step_to(4001);  chk("ms_after", rg.sys_ms, 0);
    step_to(8000);  chk("ms_second", rg.sys_ms, 1);
    step_to(12000); chk("pwr_hold", rg.pwr_rst, 1);
    step_to(12001); chk("pwr_fall", rg.pwr_rst, 0); chk("sys_in_sys", rg.sys_rst, 1);
    step_to(14000); chk("us_pre_rst", rg.sys_us, 1);
    #2 rst = 1'b1;
    #1 reset_vals("rst_sys");

    // Button held through PWR and SYS: RUN lasts one cycle, then BTN; then release.
    rg.ext_reset = 1'b0;
    release_rst();
    step_to(12000); chk("eb_pwr_hold", rg.pwr_rst, 1);
    step_to(12001); chk("eb_pwr_fall", rg.pwr_rst, 0); chk("eb_sys_hold", rg.sys_rst, 1);
    step_to(20000); chk("eb_sys_pre", rg.sys_rst, 1); chk("eb_rdy_pre", rg.sys_ready, 0);
    step_to(20001); chk("eb_sys_run", rg.sys_rst, 0); chk("eb_rdy_run", rg.sys_ready, 1);
    chk("eb_pwr_run", rg.pwr_rst, 0);
    step_to(20002); chk("eb_sys_btn", rg.sys_rst, 1); chk("eb_rdy_btn", rg.sys_ready, 0);
    chk("eb_pwr_btn", rg.pwr_rst, BTN_PWR);
    step_to(21000);
    rg.ext_reset = 1'b1;
    seen_pwr = 1'b0;
`ifdef CONFIG_RST_BTN_PWR_EN
    step_to(40000); chk("rel_pwr_hold", rg.pwr_rst, 1); chk("rel_sys_hold", rg.sys_rst, 1);
    step_to(40001); chk("rel_pwr_fall", rg.pwr_rst, 0); chk("rel_sys_in_sys", rg.sys_rst, 1);
`endif
    step_to(REL_RUN - 1); chk("rel_sys_pre", rg.sys_rst, 1); chk("rel_rdy_pre", rg.sys_ready, 0);
    step_to(REL_RUN);     chk("rel_sys_fall", rg.sys_rst, 0); chk("rel_rdy_rise", rg.sys_ready, 1);
    chk("rel_pwr_run", rg.pwr_rst, 0);
`ifndef CONFIG_RST_BTN_PWR_EN
    chk("rel_pwr_quiet", seen_pwr, 0);
`endif

    // 1.5 ms glitch in RUN must be rejected.
    step_to(G0);
    rg.ext_reset = 1'b0;
    seen_sys_hi = 1'b0;
    seen_nrdy   = 1'b0;
    step_to(G0 + 6000);
    rg.ext_reset = 1'b1;
    step_to(G0 + 9000);
    chk("glitch_sys", seen_sys_hi, 0);
    chk("glitch_rdy", seen_nrdy, 0);
    chk("glitch_btn_idle", rg.sys_ready, 1);

    // Press in RUN just before a ms strobe: sys_rst rises 2 ms + 3 cycles later.
    step_to(P);
    rg.ext_reset = 1'b0;
    step_to(P + 8002); chk("press_sys_pre", rg.sys_rst, 0); chk("press_rdy_pre", rg.sys_ready, 1);
    step_to(P + 8003); chk("press_sys_rise", rg.sys_rst, 1); chk("press_rdy_fall", rg.sys_ready, 0);
    chk("press_pwr", rg.pwr_rst, BTN_PWR);
    seen_sys_lo = 1'b0;
    step_to(P + 20000);
    chk("press_sys_stay", seen_sys_lo, 0);
    chk("press_sys_5ms", rg.sys_rst, 1);
    #2 rst = 1'b1;
    #1 reset_vals("rst_btn");

    // Sequence restarts from PWR after the second reset.
    rg.ext_reset = 1'b1;
    release_rst();
    step_to(3); chk("re_us_3", rg.sys_us, 0);
    step_to(4); chk("re_us_4", rg.sys_us, 1); chk("re_pwr", rg.pwr_rst, 1);
    chk("re_sys", rg.sys_rst, 1); chk("re_rdy", rg.sys_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
